// File: rtl/circle_dispatch_pkg.sv
// circle_dispatch_pkg: shared encodings for the circle dispatcher and its
// engine busy tracker (FSM states, plotter write-data layout, busy width).
package circle_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // Plotter write-data layout: {id[5:0], radius[7:0], ry[8:0], rx[8:0]}
    localparam int ID_LSB  = 26;
    localparam int RAD_LSB = 18;
    localparam int RY_LSB  = 9;
    localparam int RX_LSB  = 0;

    // ID 0 addresses every engine at once; circles never use it
    localparam logic [5:0] BCAST_ID = 6'd0;

    // Per-engine busy down-counter width
    localparam int BUSYW = 10;

    function automatic logic [31:0] pack_wdata(input logic [5:0] id,
                                               input logic [7:0] radius,
                                               input logic [8:0] ry,
                                               input logic [8:0] rx);
        logic [31:0] w;
        w = '0;
        w[ID_LSB  +: 6] = id;
        w[RAD_LSB +: 8] = radius;
        w[RY_LSB  +: 9] = ry;
        w[RX_LSB  +: 9] = rx;
        return w;
    endfunction

endpackage

// File: rtl/circle_dispatch_engine_busy_tracker.sv
// engine_busy_tracker: one saturating busy down-counter per plotter engine,
// the round-robin pointer, and the first-free-engine search from that pointer.
module engine_busy_tracker
    import circle_dispatch_pkg::*;
#(
    parameter int ENGINES   = 11,
    parameter int BUSY_BASE = 8,
    parameter int BUSY_MUL  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [5:0] load_id_i,
    input  logic [7:0] load_rad_i,
    output logic       any_free_o,
    output logic [5:0] next_id_o,
    output logic       all_idle_o
);

    logic [ENGINES-1:0] free;
    logic [5:0]         ptr_q;
    logic [BUSYW-1:0]   load_val;

    assign load_val = BUSYW'(BUSY_MUL * int'(load_rad_i) + BUSY_BASE);

    for (genvar g = 0; g < ENGINES; g++) begin : g_eng
        logic [BUSYW-1:0] cnt_q;

        // Busy counter: a completed write reloads it (load beats decrement)
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                cnt_q <= '0;
            else if (load_i && load_id_i == 6'(g + 1))
                cnt_q <= load_val;
            else if (cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end

        // Free is taken from the registered count, so an engine that hits 0
        // this cycle is only seen as free from the next cycle on
        assign free[g] = (cnt_q == '0);
    end

    // Round-robin pointer: one past the engine just loaded, wrapping to 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr_q <= 6'd1;
        else if (load_i)
            ptr_q <= (load_id_i >= 6'(ENGINES)) ? 6'd1 : load_id_i + 6'd1;
    end

    // First free engine at or after the pointer; scanning far-to-near lets
    // the nearest free engine overwrite the result last
    always_comb begin
        int idx;
        idx        = 0;
        next_id_o  = 6'd1;
        any_free_o = 1'b0;
        for (int k = ENGINES - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx > ENGINES) idx = idx - ENGINES;
            if (free[idx-1]) begin
                next_id_o  = 6'(idx);
                any_free_o = 1'b1;
            end
        end
    end

    assign all_idle_o = &free;

endmodule

// File: rtl/circle_dispatch.sv
// circle_dispatch: command stage for the parallel circle plotter. Schedules
// circles onto free engines (IDs 1..ENGINES) and runs full-frame clears as a
// drain followed by a broadcast write to every pixel address.
// Optional statistics outputs: define CIRCLE_DISPATCH_STATS_EN.
module circle_dispatch
    import circle_dispatch_pkg::*;
#(
    parameter int DATAW     = 18,
    parameter int ENGINES   = 11,
    parameter int BUSY_BASE = 8,
    parameter int BUSY_MUL  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clear,
    input  logic [8:0]       cmd_rx,
    input  logic [8:0]       cmd_ry,
    input  logic [7:0]       cmd_radius,
    output logic             m_write,
    output logic [DATAW-1:0] m_address,
    output logic [31:0]      m_writedata,
    input  logic             m_waitrequest,
    output logic             idle
`ifdef CIRCLE_DISPATCH_STATS_EN
    ,
    output logic [31:0]      stat_circles,
    output logic [31:0]      stat_stalls,
    output logic             stat_clear
`endif
);

    state_e           state_q;
    logic             m_write_q;
    logic [DATAW-1:0] m_address_q;
    logic [31:0]      m_writedata_q;

    logic       any_free;
    logic       all_idle;
    logic [5:0] next_id;
    logic       accept;
    logic       circ_done;

    // Ready is held low while reset is asserted even though the FSM sits in IDLE
    assign cmd_ready = reset_n && (state_q == ST_IDLE) && (cmd_clear || any_free);
    assign accept    = cmd_valid && cmd_ready;
    assign circ_done = (state_q == ST_ISSUE) && m_write_q && !m_waitrequest;

    engine_busy_tracker #(
        .ENGINES   (ENGINES),
        .BUSY_BASE (BUSY_BASE),
        .BUSY_MUL  (BUSY_MUL)
    ) u_busy (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (circ_done),
        .load_id_i  (m_writedata_q[ID_LSB +: 6]),
        .load_rad_i (m_writedata_q[RAD_LSB +: 8]),
        .any_free_o (any_free),
        .next_id_o  (next_id),
        .all_idle_o (all_idle)
    );

    // Dispatch FSM with registered write-bus outputs; a stall holds everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_clear) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            m_write_q     <= 1'b1;
                            m_writedata_q <= pack_wdata(next_id, cmd_radius, cmd_ry, cmd_rx);
                            state_q       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!m_waitrequest) begin
                        m_write_q     <= 1'b0;
                        m_writedata_q <= '0;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (all_idle) begin
                        m_address_q   <= '0;
                        m_write_q     <= 1'b1;
                        m_writedata_q <= {BCAST_ID, 26'd0};
                        state_q       <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (!m_waitrequest) begin
                        if (&m_address_q) begin
                            m_write_q   <= 1'b0;
                            m_address_q <= '0;
                            state_q     <= ST_IDLE;
                        end else begin
                            m_address_q <= m_address_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_write     = m_write_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign idle        = (state_q == ST_IDLE) && all_idle && !m_write_q;

`ifdef CIRCLE_DISPATCH_STATS_EN
    logic [31:0] stat_circles_q;
    logic [31:0] stat_stalls_q;

    // Completed circle writes and IDLE cycles where a command was refused
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_circles_q <= '0;
            stat_stalls_q  <= '0;
        end else begin
            if (circ_done)
                stat_circles_q <= stat_circles_q + 32'd1;
            if (state_q == ST_IDLE && cmd_valid && !cmd_ready)
                stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign stat_circles = stat_circles_q;
    assign stat_stalls  = stat_stalls_q;
    assign stat_clear   = (state_q == ST_DRAIN) || (state_q == ST_CLEAR);
`endif

endmodule

// File: tb/tb_circle_dispatch.sv
// tb_circle_dispatch: directed stimulus with a write scoreboard for circle_dispatch.
module tb_circle_dispatch;

    localparam int DATAW   = 13;
    localparam int ENGINES = 11;
    localparam int BB      = 8;
    localparam int BM      = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_clear = 1'b0;
    logic [8:0]       cmd_rx = '0;
    logic [8:0]       cmd_ry = '0;
    logic [7:0]       cmd_radius = '0;
    logic             m_waitrequest = 1'b0;
    logic             cmd_ready;
    logic             m_write;
    logic [DATAW-1:0] m_address;
    logic [31:0]      m_writedata;
    logic             idle;
`ifdef CIRCLE_DISPATCH_STATS_EN
    logic [31:0]      stat_circles;
    logic [31:0]      stat_stalls;
    logic             stat_clear;
`endif

    typedef struct {
        logic [DATAW-1:0] addr;
        logic [31:0]      data;
    } wr_t;

    wr_t    sb[$];
    int     vectors = 0;
    int     miscmp  = 0;
    longint cyc     = 0;

    circle_dispatch #(
        .DATAW     (DATAW),
        .ENGINES   (ENGINES),
        .BUSY_BASE (BB),
        .BUSY_MUL  (BM)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_clear     (cmd_clear),
        .cmd_rx        (cmd_rx),
        .cmd_ry        (cmd_ry),
        .cmd_radius    (cmd_radius),
        .m_write       (m_write),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .idle          (idle)
`ifdef CIRCLE_DISPATCH_STATS_EN
        ,
        .stat_circles  (stat_circles),
        .stat_stalls   (stat_stalls),
        .stat_clear    (stat_clear)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int id, input int r, input int ry, input int rx);
        return (32'(id) << 26) | (32'(r) << 18) | (32'(ry) << 9) | 32'(rx);
    endfunction

    // Scoreboard: every completed write is popped and compared in order
    always @(negedge clk) begin
        if (reset_n && m_write && !m_waitrequest) begin
            wr_t e;
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(m_address), 64'(e.addr));
                chk("wr_data", 64'(m_writedata), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one command; returns the cycle stamp of its accept edge
    task automatic send(input bit clr, input int rx, input int ry, input int r,
                        input int eid, output longint t_acc, output int waits);
        tick();
        cmd_valid  = 1'b1;
        cmd_clear  = clr;
        cmd_rx     = 9'(rx);
        cmd_ry     = 9'(ry);
        cmd_radius = 8'(r);
        waits      = 0;
        @(negedge clk);
        while (!cmd_ready && waits < 2000) begin
            waits++;
            @(negedge clk);
        end
        chk("accept_timeout", 64'(cmd_ready), 64'd1);
        if (!clr) sb.push_back('{addr: DATAW'(0), data: wd(eid, r, ry, rx)});
        @(posedge clk); #1;
        t_acc     = cyc;
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        chk(clr ? "clear_no_write_yet" : "issue_latency", 64'(m_write), clr ? 64'd0 : 64'd1);
    endtask

    // Negedges with idle low, starting at the cycle the write is completing
    task automatic busy_len(output int n);
        n = 0;
        @(negedge clk);
        while (!idle && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, sb=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        longint t[12];
        longint td;
        int     w;
        int     n;

        // Reset state, with a command waiting that must not be accepted
        #1 reset_n = 1'b0;
        cmd_valid = 1'b1;
        #2;
        chk("rst_m_write", 64'(m_write), 64'd0);
        chk("rst_m_address", 64'(m_address), 64'd0);
        chk("rst_m_writedata", 64'(m_writedata), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        cmd_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 64'(idle), 64'd1);

        // Single circle: ID 1, data 0x0450_6464, busy 3*20+8 after the write
        send(1'b0, 100, 50, 20, 1, t[0], w);
        chk("single_wdata_const", 64'(m_writedata), 64'h0450_6464);
        busy_len(n);
        chk("single_busy_len", 64'(n), 64'(BM * 20 + BB + 1));

        // Five stalled cycles in ISSUE; radius 0 loads only BUSY_BASE on completion
        tick();
        m_waitrequest = 1'b1;
        send(1'b0, 5, 6, 0, 2, t[0], w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_m_write", 64'(m_write), 64'd1);
            chk("stall_m_wdata", 64'(m_writedata), 64'(wd(2, 0, 6, 5)));
        end
        @(posedge clk); #1;
        m_waitrequest = 1'b0;
        busy_len(n);
        chk("stall_busy_len_r0", 64'(n), 64'(BB + 1));

        // Twelve back-to-back r=255 circles after reset: IDs 1..11 then wrap to 1
        do_reset();
        for (int k = 0; k < ENGINES; k++) begin
            send(1'b0, k, k + 1, 255, k + 1, t[k], w);
            if (k != 0) begin
                td = t[k] - t[k-1];
                chk("b2b_interval", 64'(td), 64'd2);
            end
        end
        send(1'b0, 7, 8, 255, 1, t[11], w);
        td = t[11] - t[0];
        chk("wrap_wait_for_eng1", 64'(td), 64'(BM * 255 + BB + 2));
`ifdef CIRCLE_DISPATCH_STATS_EN
        tick();
        chk("stat_circles", 64'(stat_circles), 64'd12);
        chk("stat_stalls", 64'(stat_stalls), 64'(BM * 255 + BB + 2 - 22));
`endif

        // Circle then clear: drain lasts the circle's busy time, then full sweep
        @(negedge clk);
        n = 0;
        while (!idle && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("idle_before_clear", 64'(idle), 64'd1);
        send(1'b0, 1, 2, 10, 2, t[0], w);
        for (int a = 0; a < (1 << DATAW); a++) sb.push_back('{addr: DATAW'(a), data: 32'd0});
        send(1'b1, 511, 511, 255, 0, t[0], w);
        n = 0;
        @(negedge clk);
`ifdef CIRCLE_DISPATCH_STATS_EN
        chk("stat_clear_drain", 64'(stat_clear), 64'd1);
`endif
        while (!m_write && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_len", 64'(n), 64'(BM * 10 + BB));
        n = 0;
        while (sb.size() != 0 && n < 30000) begin
            @(posedge clk); #1;
            m_waitrequest = ($urandom_range(0, 3) == 0);
            n++;
        end
        m_waitrequest = 1'b0;
        chk("clear_all_written", 64'(sb.size()), 64'd0);
        chk("idle_after_clear", 64'(idle), 64'd1);
        chk("m_address_after_clear", 64'(m_address), 64'd0);
        tick();
        chk("no_write_after_clear", 64'(m_write), 64'd0);

        // Reset in the middle of a clear sweep at address 0x1234
        for (int a = 0; a <= 'h1234; a++) sb.push_back('{addr: DATAW'(a), data: 32'd0});
        send(1'b1, 0, 0, 0, 0, t[0], w);
        n = 0;
        @(negedge clk);
        while (!(m_write && m_address == DATAW'('h1234)) && n < 10000) begin
            n++;
            @(negedge clk);
        end
        chk("reached_0x1234", 64'(m_address), 64'h1234);
        #1 reset_n = 1'b0;
        #1;
        chk("midclear_rst_m_write", 64'(m_write), 64'd0);
        chk("midclear_rst_m_address", 64'(m_address), 64'd0);
        chk("midclear_rst_idle", 64'(idle), 64'd1);
        chk("midclear_sb_drained", 64'(sb.size()), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        send(1'b0, 300, 200, 1, 1, t[0], w);
        busy_len(n);
        chk("post_reset_busy_len", 64'(n), 64'(BM * 1 + BB + 1));
        tick();
        tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule

// File: doc/circle_dispatch.md
Name: circle_dispatch

Overview:
- Upstream command stage for the parallel circle plotter.
- Accepts circle descriptors and frame-clear commands from a valid/ready stream and schedules each circle onto a free plotter engine (IDs 1..ENGINES).
- Issues 32-bit memory-mapped writes to the plotter slave, tracking per-engine busy time.
- For a clear, drains all engines, then sweeps every pixel address with broadcast (ID 0) writes.

Parameters:
- DATAW, 18, pixel address width ({y[8:0], x[8:0]}).
- ENGINES, 11, number of plotter engines; legal 1..63.
- BUSY_BASE, 8, fixed busy-cycle allowance per circle.
- BUSY_MUL, 3, busy cycles per radius unit.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid and cmd_ready are both 1.
- cmd_clear  in  1  1 = frame-clear command; the coordinate fields are ignored.
- cmd_rx  in  9  circle centre x.
- cmd_ry  in  9  circle centre y.
- cmd_radius  in  8  circle radius.
- m_write  out  1  write request to the plotter slave.
- m_address  out  DATAW  write address; used only by clear writes, 0 otherwise.
- m_writedata  out  32  {id[5:0], radius[7:0], ry[8:0], rx[8:0]}.
- m_waitrequest  in  1  slave stall; m_write, m_address and m_writedata hold while it is high.
- idle  out  1  FSM in IDLE, all busy counters 0, no pending write.

Behaviour:
- Reset: clk and reset_n, asynchronous active-low.
  - On assertion, all outputs and state clear immediately: m_write=0, m_address=0, m_writedata=0, cmd_ready=0, idle=1 (idle follows reset release).
  - Busy counters 0, round-robin pointer = engine 1, FSM = IDLE.
  - Reset mid-clear or mid-issue abandons the operation with no further writes.
- Busy tracking:
  - One down-counter per engine, 10 bits, saturating at 0.
  - On the cycle a circle write completes (m_write=1 and m_waitrequest=0), the target counter loads BUSY_MUL*radius + BUSY_BASE.
  - This bound is at least the plotter's worst-case octant walk plus its four-write-per-step sequence.
- FSM states: IDLE, ISSUE, DRAIN, CLEAR.
  - IDLE: cmd_ready=1 only if (cmd_clear=0 and some engine is free) or cmd_clear=1.
    - Circle accept: latch fields; target = first free engine at or after the RR pointer, wrapping ENGINES->1; -> ISSUE.
    - Clear accept: -> DRAIN.
  - ISSUE: m_write=1, m_writedata={target, radius, ry, rx}, m_address=0.
    - On the cycle with no waitrequest: load the target counter, set RR pointer = target+1 (wrapping), -> IDLE.
  - DRAIN: m_write=0; wait until all counters are 0, then m_address=0 -> CLEAR.
  - CLEAR: m_write=1, m_writedata=0 (ID 0 = broadcast clear).
    - m_address increments on each non-stalled write.
    - After the write to address 2^DATAW-1 completes -> IDLE; the address does not wrap further.
- Latency: command accepted in cycle N -> m_write high in cycle N+1 (registered outputs). Back-to-back circles sustain one write every 2 cycles.
- Simultaneous events:
  - A counter load and decrement in the same cycle: the load wins.
  - A counter reaching 0 in the same cycle as the IDLE free-engine check: the engine counts as not free until the next cycle.
- Radius 0 is legal; busy = BUSY_BASE.
- cmd_ready is 0 in ISSUE, DRAIN and CLEAR.
- Engine ID 0 is never used for circles.

Optional Feature:
- Macro: CIRCLE_DISPATCH_STATS_EN.
- When defined, three outputs are added:
  - stat_circles [31:0]: circle writes completed, wrapping.
  - stat_stalls [31:0]: cycles in IDLE with cmd_valid=1 and cmd_ready=0.
  - stat_clear [0]: 1 while in DRAIN or CLEAR.
  - The counters reset to 0 on reset_n only.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/DRAIN/CLEAR); writedata field offsets (ID_LSB=26, RAD_LSB=18, RY_LSB=9, RX_LSB=0); broadcast ID constant 0; busy-counter width 10.
- One natural sub-module, engine_busy_tracker: owns the ENGINES counters, the round-robin pointer and the free-engine search; outputs any_free and next_id.

Test Plan:
- Reset then a single circle (rx=100, ry=50, r=20) -> one cycle later m_writedata = 0x0450_6464 (ID 1) for one cycle; engine 1 busy 68 cycles.
- 12 back-to-back circles (r=255), ENGINES=11 -> IDs 1..11 assigned in order; 12th stalls (cmd_ready=0) until engine 1's counter (773) expires, then gets ID 1.
- Circle followed by clear -> DRAIN holds until the counter hits 0; then 2^18 writes with data 0, addresses 0..0x3FFFF ascending; idle=1 afterward.
- m_waitrequest high for 5 cycles during ISSUE -> m_write/m_writedata stable for the whole stall; busy load happens only on the accept cycle.
- reset_n low mid-CLEAR at address 0x1234 -> m_write=0 immediately; after release idle=1 and the next circle gets ID 1.
- With CIRCLE_DISPATCH_STATS_EN, 3 circles plus 10 stall cycles -> stat_circles=3, stat_stalls=10.
